// File: rtl/axi4_mem_arbiter_if.sv
// Single-beat AXI4-style memory bus between the arbiter (master) and the shared
// 32x16 memory slave: separate AW/W/B write channels and AR/R read channels.
interface axi4_mem_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] M_A_W_ADDR;
   logic              M_A_W_VALID;
   logic              M_A_W_READY;
   logic [DATA_W-1:0] M_W_DATA;
   logic              M_W_VALID;
   logic              M_W_READY;
   logic              M_B_VALID;
   logic [1:0]        M_B_RESP;
   logic              M_B_READY;
   logic [ADDR_W-1:0] M_A_R_ADDR;
   logic              M_A_R_VALID;
   logic              M_A_R_READY;
   logic [DATA_W-1:0] M_R_DATA;
   logic              M_R_VALID;
   logic              M_R_READY;

   modport master (
      output M_A_W_ADDR, M_A_W_VALID, input M_A_W_READY,
      output M_W_DATA, M_W_VALID, input M_W_READY,
      input M_B_VALID, M_B_RESP, output M_B_READY,
      output M_A_R_ADDR, M_A_R_VALID, input M_A_R_READY,
      input M_R_DATA, M_R_VALID, output M_R_READY
   );

   modport slave (
      input M_A_W_ADDR, M_A_W_VALID, output M_A_W_READY,
      input M_W_DATA, M_W_VALID, output M_W_READY,
      output M_B_VALID, M_B_RESP, input M_B_READY,
      input M_A_R_ADDR, M_A_R_VALID, output M_A_R_READY,
      output M_R_DATA, M_R_VALID, input M_R_READY
   );
endinterface

// File: rtl/axi4_mem_arbiter.sv
// Round-robin arbiter for two REQ/GNT/DONE requesters in front of one AXI4-style
// memory slave; one single-beat transaction is outstanding at a time.
module axi4_mem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              REQ0_i,
   input  logic              WE0_i,
   input  logic [ADDR_W-1:0] ADDR0_i,
   input  logic [DATA_W-1:0] WDATA0_i,
   output logic              GNT0_o,
   output logic              DONE0_o,
   output logic [DATA_W-1:0] RDATA0_o,
   output logic [1:0]        RESP0_o,
   input  logic              REQ1_i,
   input  logic              WE1_i,
   input  logic [ADDR_W-1:0] ADDR1_i,
   input  logic [DATA_W-1:0] WDATA1_i,
   output logic              GNT1_o,
   output logic              DONE1_o,
   output logic [DATA_W-1:0] RDATA1_o,
   output logic [1:0]        RESP1_o,
   axi4_mem_arbiter_if.master m_if
);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
   localparam logic [2:0] S_WR_RESP      = 3'd2;
   localparam logic [2:0] S_RD_ADDR      = 3'd3;
   localparam logic [2:0] S_RD_DATA      = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              last_q, last_d;
   logic              sel_q, sel_d;
   logic              aw_valid_q, aw_valid_d;
   logic              w_valid_q, w_valid_d;
   logic              b_ready_q, b_ready_d;
   logic              ar_valid_q, ar_valid_d;
   logic              r_ready_q, r_ready_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        done_q, done_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [1:0]        resp0_q, resp0_d, resp1_q, resp1_d;

   logic              pick;
   logic              pick_we;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] pick_wdata;

   // On a tie the requester that was not granted last wins.
   assign pick       = (REQ0_i && REQ1_i) ? ~last_q : REQ1_i;
   assign pick_we    = pick ? WE1_i : WE0_i;
   assign pick_addr  = pick ? ADDR1_i : ADDR0_i;
   assign pick_wdata = pick ? WDATA1_i : WDATA0_i;

   always_comb begin
      // NOTE: every next-state signal starts from its current value so no path infers a latch.
      state_d    = state_q;
      last_d     = last_q;
      sel_d      = sel_q;
      aw_valid_d = aw_valid_q;
      w_valid_d  = w_valid_q;
      b_ready_d  = b_ready_q;
      ar_valid_d = ar_valid_q;
      r_ready_d  = r_ready_q;
      aw_addr_d  = aw_addr_q;
      ar_addr_d  = ar_addr_q;
      w_data_d   = w_data_q;
      gnt_d      = 2'b00;
      done_d     = 2'b00;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      resp0_d    = resp0_q;
      resp1_d    = resp1_q;

      case (state_q)
         S_IDLE: begin
            if (REQ0_i || REQ1_i) begin
               sel_d  = pick;
               last_d = pick;
               gnt_d  = pick ? 2'b10 : 2'b01;
               if (pick_we) begin
                  aw_addr_d  = pick_addr;
                  w_data_d   = pick_wdata;
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
                  state_d    = S_WR_ADDR_DATA;
               end else begin
                  ar_addr_d  = pick_addr;
                  ar_valid_d = 1'b1;
                  state_d    = S_RD_ADDR;
               end
            end
         end

         S_WR_ADDR_DATA: begin
            if (aw_valid_q && m_if.M_A_W_READY) aw_valid_d = 1'b0;
            if (w_valid_q && m_if.M_W_READY)    w_valid_d  = 1'b0;
            // A channel whose VALID is already low finished its handshake earlier.
            if ((!aw_valid_q || m_if.M_A_W_READY) && (!w_valid_q || m_if.M_W_READY))
               state_d = S_WR_RESP;
         end

         S_WR_RESP: begin
            if (m_if.M_B_VALID) begin
               if (b_ready_q) begin
                  b_ready_d = 1'b0;
                  done_d    = sel_q ? 2'b10 : 2'b01;
                  if (sel_q) resp1_d = m_if.M_B_RESP;
                  else       resp0_d = m_if.M_B_RESP;
                  state_d   = S_IDLE;
               end else begin
                  b_ready_d = 1'b1;
               end
            end
         end

         S_RD_ADDR: begin
            if (m_if.M_A_R_READY) begin
               ar_valid_d = 1'b0;
               state_d    = S_RD_DATA;
            end
         end

         S_RD_DATA: begin
            if (m_if.M_R_VALID) begin
               if (r_ready_q) begin
                  r_ready_d = 1'b0;
                  done_d    = sel_q ? 2'b10 : 2'b01;
                  if (sel_q) begin
                     rdata1_d = m_if.M_R_DATA;
                     resp1_d  = 2'b00;
                  end else begin
                     rdata0_d = m_if.M_R_DATA;
                     resp0_d  = 2'b00;
                  end
                  state_d   = S_IDLE;
               end else begin
                  r_ready_d = 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         last_q     <= 1'b1;
         sel_q      <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         aw_addr_q  <= '0;
         ar_addr_q  <= '0;
         w_data_q   <= '0;
         gnt_q      <= 2'b00;
         done_q     <= 2'b00;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         resp0_q    <= 2'b00;
         resp1_q    <= 2'b00;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         sel_q      <= sel_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         b_ready_q  <= b_ready_d;
         ar_valid_q <= ar_valid_d;
         r_ready_q  <= r_ready_d;
         aw_addr_q  <= aw_addr_d;
         ar_addr_q  <= ar_addr_d;
         w_data_q   <= w_data_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         resp0_q    <= resp0_d;
         resp1_q    <= resp1_d;
      end
   end

   assign GNT0_o   = gnt_q[0];
   assign GNT1_o   = gnt_q[1];
   assign DONE0_o  = done_q[0];
   assign DONE1_o  = done_q[1];
   assign RDATA0_o = rdata0_q;
   assign RDATA1_o = rdata1_q;
   assign RESP0_o  = resp0_q;
   assign RESP1_o  = resp1_q;

   assign m_if.M_A_W_ADDR  = aw_addr_q;
   assign m_if.M_A_W_VALID = aw_valid_q;
   assign m_if.M_W_DATA    = w_data_q;
   assign m_if.M_W_VALID   = w_valid_q;
   assign m_if.M_B_READY   = b_ready_q;
   assign m_if.M_A_R_ADDR  = ar_addr_q;
   assign m_if.M_A_R_VALID = ar_valid_q;
   assign m_if.M_R_READY   = r_ready_q;

endmodule

// File: doc/axi4_mem_arbiter.md
Name: axi4_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared AXI4-style 32x16 memory slave.
- Each requester issues single-beat read or write commands on a simple REQ/GNT/DONE interface.
- The block grants one requester at a time using round-robin priority. It drives the slave's separate AW/W/B and AR/R channels, then returns read data and response to the granted requester.
- Exactly one memory transaction is outstanding at any time.

Parameters:
ADDR_W, 5, address width to slave and requesters
DATA_W, 16, data width

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  reset, asynchronous, active-high
REQn (n=0,1)  in  1  requester n command request, held until GNTn
WEn  in  1  1=write, 0=read; valid with REQn
ADDRn  in  ADDR_W  command address
WDATAn  in  DATA_W  write data
GNTn  out  1  one-cycle pulse: command latched
DONEn  out  1  one-cycle pulse: transaction complete
RDATAn  out  DATA_W  read data, held until next read completion for n
RESPn  out  2  completion response, held (write: slave B_RESP; read: 2'b00)
M_A_W_ADDR / M_A_W_VALID / M_A_W_READY  out/out/in  ADDR_W/1/1  write address channel
M_W_DATA / M_W_VALID / M_W_READY  out/out/in  DATA_W/1/1  write data channel
M_B_VALID / M_B_RESP / M_B_READY  in/in/out  1/2/1  write response channel
M_A_R_ADDR / M_A_R_VALID / M_A_R_READY  out/out/in  ADDR_W/1/1  read address channel
M_R_DATA / M_R_VALID / M_R_READY  in/in/out  DATA_W/1/1  read data channel

Behaviour:
- Reset: all outputs 0 (RDATAn=0, RESPn=2'b00), FSM=IDLE, LAST (last granted)=1, so requester 0 wins the first tie. Reset mid-transaction abandons it; no DONE is issued.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE arbitration, at each clock edge:
  - Exactly one REQn=1: grant n.
  - Both REQn=1: grant the requester != LAST.
  - On grant: latch WE/ADDR/WDATA, pulse GNTn (high the following cycle), update LAST.
  - Next state: WR_ADDR_DATA if WE=1, else RD_ADDR.
- REQn while not in IDLE: ignored, stays pending, no GNT.
- The REQn still high during its GNTn cycle is not re-sampled, because the FSM has already left IDLE.
- WR_ADDR_DATA:
  - On entry, M_A_W_VALID=1 and M_W_VALID=1 with the latched address and data; both are stable while VALID is high.
  - Each VALID drops at the edge where VALID&&READY. The two channels complete independently, in either order.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP: M_B_READY is registered.
  - Assert it at the edge after M_B_VALID is first sampled high; never assert it before B_VALID.
  - The handshake is the edge with B_VALID&&B_READY. At that edge: drop B_READY, RESPn<=M_B_RESP, DONEn pulse, go to IDLE.
- RD_ADDR: M_A_R_VALID=1 with the latched address; drop it on the AR handshake edge, go to RD_DATA.
- RD_DATA: M_R_READY is registered, asserted at the edge after M_R_VALID is first sampled high.
  - At the R_VALID&&R_READY edge: RDATAn<=M_R_DATA, RESPn<=2'b00, DONEn pulse, drop R_READY, go to IDLE.
- Back-to-back: IDLE arbitration runs in the same cycle DONE is high, so there is no dead cycle between transactions.
- Unused channel outputs are 0. M_* address/data outputs hold their last value when VALID is low.
- No timeout: a non-responding slave stalls the FSM until RESET.
- GNTn and DONEn never assert for both n in the same cycle.

Test Plan:
- Single write: REQ0=1, WE0=1, ADDR0=5'h03, WDATA0=16'hA5A5, slave responds -> GNT0 one cycle, AW/W carry 03/A5A5, B_READY only after B_VALID, DONE0 pulse, RESP0=2'b00.
- Single read-back: REQ1 read of ADDR1=5'h03 after the write above -> AR addr 03, R_READY asserted one cycle after R_VALID, DONE1 pulse, RDATA1=16'hA5A5.
- Contention: REQ0 and REQ1 both high from reset, both held after service -> grant order 0,1,0,1; each DONE precedes the next GNT; GNT0/GNT1 never overlap.
- Request while busy: REQ1 raised during requester 0's WR_RESP -> no GNT1 until the cycle after DONE0, then GNT1 with no idle cycle.
- Slave stall: hold M_B_VALID low for 10 cycles -> FSM remains in WR_RESP, B_READY stays 0, no DONE, VALIDs stable; release -> normal completion.
- Reset mid-read: assert RESET in RD_DATA -> all outputs 0 immediately, no DONE; after release, a tie grants requester 0 first.
